avalon_st_pkt_fifo: RTL and testbench

Synchronous Avalon-ST packet FIFO, the next generation of the team's single-clock packet FIFO. It adds a runtime-selectable mode: store-and-forward with packet drop, or cut-through with backpressure. Packets are committed and rolled back through a commit pointer instead of pointer arithmetic. Packets flagged with an error are dropped, along with malformed framing. It sits between the MAC/parser side and downstream packet processing.

---
 rtl/avalon_st_pkt_fifo.sv | 210 +++++++++++++++++++++
 tb/tb_avalon_st_pkt_fifo.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/avalon_st_pkt_fifo.sv
// Single-clock Avalon-ST packet FIFO: store-and-forward with drop, or cut-through; AVST_PKT_FIFO_DROP_CNT_EN adds drop counter.
// Commit-to-src_valid latency 2 cycles; drop mode never backpressures, cut-through deasserts snk_ready_o when full.
module avalon_st_pkt_fifo #(
  parameter int DATA_WIDTH      = 64,
  parameter int CHANNEL_WIDTH   = 8,
  parameter int EMPTY_WIDTH     = $clog2(DATA_WIDTH/8),
  parameter int WORDS_AMOUNT    = 16,
  parameter int ADDR_WIDTH      = $clog2(WORDS_AMOUNT),
  parameter int ALMOST_FULL_LVL = WORDS_AMOUNT-4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     drop_mode_i,
  input  logic [DATA_WIDTH-1:0]    snk_data_i,
  input  logic [EMPTY_WIDTH-1:0]   snk_empty_i,
  input  logic [CHANNEL_WIDTH-1:0] snk_channel_i,
  input  logic                     snk_sop_i,
  input  logic                     snk_eop_i,
  input  logic                     snk_error_i,
  input  logic                     snk_valid_i,
  output logic                     snk_ready_o,
  output logic [DATA_WIDTH-1:0]    src_data_o,
  output logic [EMPTY_WIDTH-1:0]   src_empty_o,
  output logic [CHANNEL_WIDTH-1:0] src_channel_o,
  output logic                     src_sop_o,
  output logic                     src_eop_o,
  output logic                     src_error_o,
  output logic                     src_valid_o,
  input  logic                     src_ready_i,
  output logic [ADDR_WIDTH:0]      used_words_o,
  output logic [ADDR_WIDTH:0]      pkts_amount_o,
  output logic                     full_o,
  output logic                     almost_full_o,
  output logic                     empty_o,
  output logic                     drop_o,
  output logic [15:0]              drop_cnt_o
);
  localparam int WW = DATA_WIDTH + CHANNEL_WIDTH + EMPTY_WIDTH + 3;
  localparam int PW = ADDR_WIDTH + 1;

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_DROP} state_t;

  state_t                r_state, w_state_nxt;
  logic                  r_mode;
  logic [WW-1:0]         r_mem [WORDS_AMOUNT];
  logic [PW-1:0]         r_wr_ptr, r_commit_ptr, r_commit_vis, r_rd_ptr, r_out_cnt;
  logic [PW-1:0]         r_used, r_pkts;
  logic                  r_full, r_afull, r_drop, r_src_vld;
  logic [WW-1:0]         r_src_dat;

  logic                  w_acc, w_read, w_load, w_wr_en, w_pkt_inc, w_drop;
  logic [ADDR_WIDTH-1:0] w_wr_addr;
  logic [PW-1:0]         w_wr_ptr_nxt, w_commit_nxt, w_wr_inc, w_cm_inc;
  logic [PW-1:0]         w_out_cnt_nxt, w_used_nxt, w_pkts_nxt;
  logic [WW-1:0]         w_wr_dat, w_rd_dat;

  assign snk_ready_o = r_mode | ~r_full;
  assign w_acc       = snk_valid_i & snk_ready_o;
  assign w_wr_dat    = {snk_error_i, snk_sop_i, snk_eop_i, snk_empty_i, snk_channel_i, snk_data_i};
  assign w_wr_inc    = r_wr_ptr + PW'(1);
  assign w_cm_inc    = r_commit_ptr + PW'(1);

  // Write side: wr_ptr runs ahead speculatively, commit_ptr is only moved on a clean eop.
  always_comb begin
    w_state_nxt  = r_state;
    w_wr_en      = 1'b0;
    w_wr_addr    = r_wr_ptr[ADDR_WIDTH-1:0];
    w_wr_ptr_nxt = r_wr_ptr;
    w_commit_nxt = r_commit_ptr;
    w_pkt_inc    = 1'b0;
    w_drop       = 1'b0;
    if (!r_mode) begin
      w_state_nxt = S_IDLE;
      if (w_acc) begin
        w_wr_en      = 1'b1;
        w_wr_ptr_nxt = w_wr_inc;
        w_commit_nxt = w_wr_inc;
        w_pkt_inc    = snk_eop_i;
      end
    end else begin
      case (r_state)
        S_IDLE: if (w_acc) begin
          if (!snk_sop_i || r_full) begin
            w_drop = 1'b1;
            if (!snk_eop_i) w_state_nxt = S_DROP;
          end else if (snk_eop_i && snk_error_i) begin
            w_drop = 1'b1;
          end else begin
            w_wr_en      = 1'b1;
            w_wr_ptr_nxt = w_wr_inc;
            if (snk_eop_i) begin
              w_commit_nxt = w_wr_inc;
              w_pkt_inc    = 1'b1;
            end else begin
              w_state_nxt = S_WRITE;
            end
          end
        end
        S_WRITE: if (w_acc) begin
          if (r_full) begin
            w_drop       = 1'b1;
            w_wr_ptr_nxt = r_commit_ptr;
            w_state_nxt  = snk_eop_i ? S_IDLE : S_DROP;
          end else if (snk_sop_i) begin
            // Restart: the new sop word overwrites the first slot of the abandoned packet.
            w_drop       = 1'b1;
            w_wr_en      = 1'b1;
            w_wr_addr    = r_commit_ptr[ADDR_WIDTH-1:0];
            w_wr_ptr_nxt = w_cm_inc;
            if (snk_eop_i) begin
              w_state_nxt = S_IDLE;
              if (snk_error_i) begin
                w_wr_ptr_nxt = r_commit_ptr;
              end else begin
                w_commit_nxt = w_cm_inc;
                w_pkt_inc    = 1'b1;
              end
            end
          end else if (snk_eop_i) begin
            w_state_nxt = S_IDLE;
            if (snk_error_i) begin
              w_drop       = 1'b1;
              w_wr_ptr_nxt = r_commit_ptr;
            end else begin
              w_wr_en      = 1'b1;
              w_wr_ptr_nxt = w_wr_inc;
              w_commit_nxt = w_wr_inc;
              w_pkt_inc    = 1'b1;
            end
          end else begin
            w_wr_en      = 1'b1;
            w_wr_ptr_nxt = w_wr_inc;
          end
        end
        S_DROP: if (w_acc && snk_eop_i) w_state_nxt = S_IDLE;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  assign w_rd_dat      = r_mem[r_rd_ptr[ADDR_WIDTH-1:0]];
  assign w_read        = r_src_vld & src_ready_i;
  assign w_load        = (r_rd_ptr != r_commit_vis) & (~r_src_vld | src_ready_i);
  assign w_out_cnt_nxt = r_out_cnt + PW'(w_read);
  assign w_used_nxt    = w_wr_ptr_nxt - w_out_cnt_nxt;
  assign w_pkts_nxt    = r_pkts + PW'(w_pkt_inc) - PW'(w_read & src_eop_o);

  always_ff @(posedge clk_i) begin
    if (w_wr_en) r_mem[w_wr_addr] <= w_wr_dat;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state      <= S_IDLE;
      r_mode       <= 1'b1;
      r_wr_ptr     <= '0;
      r_commit_ptr <= '0;
      r_commit_vis <= '0;
      r_rd_ptr     <= '0;
      r_out_cnt    <= '0;
      r_used       <= '0;
      r_pkts       <= '0;
      r_full       <= 1'b0;
      r_afull      <= 1'b0;
      r_drop       <= 1'b0;
      r_src_vld    <= 1'b0;
      r_src_dat    <= '0;
    end else begin
      r_state      <= w_state_nxt;
      if (r_state == S_IDLE && r_wr_ptr == r_commit_ptr) r_mode <= drop_mode_i;
      r_wr_ptr     <= w_wr_ptr_nxt;
      r_commit_ptr <= w_commit_nxt;
      // One-cycle delayed view of the commit point gives the two-cycle commit-to-valid latency.
      r_commit_vis <= r_commit_ptr;
      r_out_cnt    <= w_out_cnt_nxt;
      r_used       <= w_used_nxt;
      r_pkts       <= w_pkts_nxt;
      r_full       <= (w_used_nxt == PW'(WORDS_AMOUNT));
      r_afull      <= (w_used_nxt >= PW'(ALMOST_FULL_LVL));
      r_drop       <= w_drop;
      if (w_load) begin
        r_src_dat <= w_rd_dat;
        r_src_vld <= 1'b1;
        r_rd_ptr  <= r_rd_ptr + PW'(1);
      end else if (w_read) begin
        r_src_vld <= 1'b0;
      end
    end
  end

  assign {src_error_o, src_sop_o, src_eop_o, src_empty_o, src_channel_o, src_data_o} = r_src_dat;
  assign src_valid_o   = r_src_vld;
  assign empty_o       = ~r_src_vld;
  assign used_words_o  = r_used;
  assign pkts_amount_o = r_pkts;
  assign full_o        = r_full;
  assign almost_full_o = r_afull;
  assign drop_o        = r_drop;

`ifdef AVST_PKT_FIFO_DROP_CNT_EN
  logic [15:0] r_drop_cnt;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                               r_drop_cnt <= '0;
    else if (w_drop && r_drop_cnt != 16'hFFFF) r_drop_cnt <= r_drop_cnt + 16'd1;
  end
  assign drop_cnt_o = r_drop_cnt;
`else
  assign drop_cnt_o = '0;
`endif
endmodule

// File: tb/tb_avalon_st_pkt_fifo.sv
// Bench for avalon_st_pkt_fifo: queue-level packet model checked every cycle plus directed literal checks.
module tb_avalon_st_pkt_fifo;
  localparam int DW = 64, CW = 8, EW = 3, AW = 4;
`ifdef AVST_PKT_FIFO_DROP_CNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  logic          clk_i = 1'b0, rst_i = 1'b1, drop_mode_i = 1'b1;
  logic [DW-1:0] snk_data_i = '0;
  logic [EW-1:0] snk_empty_i = '0;
  logic [CW-1:0] snk_channel_i = '0;
  logic          snk_sop_i = 1'b0, snk_eop_i = 1'b0, snk_error_i = 1'b0, snk_valid_i = 1'b0;
  logic          src_ready_i = 1'b1;
  logic          snk_ready_o;
  logic [DW-1:0] src_data_o;
  logic [EW-1:0] src_empty_o;
  logic [CW-1:0] src_channel_o;
  logic          src_sop_o, src_eop_o, src_error_o, src_valid_o;
  logic [AW:0]   used_words_o, pkts_amount_o;
  logic          full_o, almost_full_o, empty_o, drop_o;
  logic [15:0]   drop_cnt_o;

  avalon_st_pkt_fifo dut (
    .clk_i(clk_i), .rst_i(rst_i), .drop_mode_i(drop_mode_i),
    .snk_data_i(snk_data_i), .snk_empty_i(snk_empty_i), .snk_channel_i(snk_channel_i),
    .snk_sop_i(snk_sop_i), .snk_eop_i(snk_eop_i), .snk_error_i(snk_error_i),
    .snk_valid_i(snk_valid_i), .snk_ready_o(snk_ready_o),
    .src_data_o(src_data_o), .src_empty_o(src_empty_o), .src_channel_o(src_channel_o),
    .src_sop_o(src_sop_o), .src_eop_o(src_eop_o), .src_error_o(src_error_o),
    .src_valid_o(src_valid_o), .src_ready_i(src_ready_i),
    .used_words_o(used_words_o), .pkts_amount_o(pkts_amount_o),
    .full_o(full_o), .almost_full_o(almost_full_o), .empty_o(empty_o),
    .drop_o(drop_o), .drop_cnt_o(drop_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [63:0] d; logic [7:0] ch; logic [2:0] em; logic s; logic p; logic r;
  } wrd_t;

  wrd_t        part_q[$];
  wrd_t        out_q[$];
  bit          m_mode = 1'b1, m_wr = 1'b0, m_dp = 1'b0, m_drop = 1'b0;
  logic [15:0] m_dcnt = '0;
  int          n_rd = 0, n_sop = 0;
  bit          last_err = 1'b0;

  int total = 0, bad = 0, n_drop = 0;
  bit vld_seen = 1'b0;

  function automatic int m_used();
    return part_q.size() + out_q.size();
  endfunction

  function automatic int m_pkts();
    int c = 0;
    foreach (out_q[i]) if (out_q[i].p) c++;
    return c;
  endfunction

  function automatic void commit();
    foreach (part_q[i]) out_q.push_back(part_q[i]);
    part_q.delete();
  endfunction

  // Packet-level model: uncommitted words in part_q, readable words in out_q.
  initial forever begin
    wrd_t w;
    bit   full, acc, dr, idle;
    @(posedge clk_i or posedge rst_i);
    if (rst_i) begin
      part_q.delete(); out_q.delete();
      m_mode = 1'b1; m_wr = 1'b0; m_dp = 1'b0; m_drop = 1'b0; m_dcnt = '0;
    end else begin
      full = (m_used() == 16);
      acc  = snk_valid_i && (m_mode || !full);
      w    = {snk_data_i, snk_channel_i, snk_empty_i, snk_sop_i, snk_eop_i, snk_error_i};
      dr   = 1'b0;
      idle = !m_wr && !m_dp;
      if (src_valid_o && src_ready_i && out_q.size() > 0) begin
        n_rd++;
        if (src_sop_o) n_sop++;
        last_err = src_error_o;
        void'(out_q.pop_front());
      end
      if (acc) begin
        if (!m_mode) out_q.push_back(w);
        else if (m_dp) begin
          if (w.p) m_dp = 1'b0;
        end else if (m_wr) begin
          if (full) begin
            part_q.delete(); dr = 1'b1; m_wr = 1'b0; m_dp = !w.p;
          end else if (w.s) begin
            part_q.delete(); dr = 1'b1; part_q.push_back(w);
            if (w.p) begin
              if (w.r) part_q.delete(); else commit();
              m_wr = 1'b0;
            end
          end else if (w.p) begin
            if (w.r) begin part_q.delete(); dr = 1'b1; end
            else begin part_q.push_back(w); commit(); end
            m_wr = 1'b0;
          end else part_q.push_back(w);
        end else begin
          if (!w.s || full) begin dr = 1'b1; m_dp = !w.p; end
          else if (w.p && w.r) dr = 1'b1;
          else begin
            part_q.push_back(w);
            if (w.p) commit(); else m_wr = 1'b1;
          end
        end
      end
      if (idle) m_mode = drop_mode_i;
      m_drop = dr;
      if (dr && CNT_ON && m_dcnt != 16'hFFFF) m_dcnt = m_dcnt + 16'd1;
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  task automatic cmp_all();
    chk("used", 64'(used_words_o), 64'(m_used()));
    chk("pkts", 64'(pkts_amount_o), 64'(m_pkts()));
    chk("full", 64'(full_o), 64'(m_used() == 16));
    chk("afull", 64'(almost_full_o), 64'(m_used() >= 12));
    chk("empty", 64'(empty_o), 64'(!src_valid_o));
    chk("snk_ready", 64'(snk_ready_o), 64'(m_mode || m_used() != 16));
    chk("drop", 64'(drop_o), 64'(m_drop));
    chk("drop_cnt", 64'(drop_cnt_o), 64'(m_dcnt));
    if (src_valid_o) begin
      chk("q_nonempty", 64'(out_q.size() != 0), 64'(1));
      if (out_q.size() != 0) begin
        chk("src_data", src_data_o, out_q[0].d);
        chk("src_ch", 64'(src_channel_o), 64'(out_q[0].ch));
        chk("src_empty", 64'(src_empty_o), 64'(out_q[0].em));
        chk("src_sop", 64'(src_sop_o), 64'(out_q[0].s));
        chk("src_eop", 64'(src_eop_o), 64'(out_q[0].p));
        chk("src_err", 64'(src_error_o), 64'(out_q[0].r));
      end
    end
    n_drop += int'(drop_o);
    vld_seen |= src_valid_o;
  endtask

  task automatic step();
    @(posedge clk_i);
    @(negedge clk_i);
    cmp_all();
  endtask

  function automatic logic [63:0] wd(input int id, input int i);
    return 64'hA000_0000_0000_0000 | (64'(id) << 8) | 64'(i);
  endfunction

  task automatic send_word(input int id, input int i, input logic s, input logic p, input logic r);
    bit rdy;
    bit ok = 1'b0;
    snk_data_i = wd(id, i); snk_channel_i = 8'(id); snk_empty_i = p ? 3'd5 : 3'd0;
    snk_sop_i = s; snk_eop_i = p; snk_error_i = r; snk_valid_i = 1'b1;
    for (int k = 0; k < 100 && !ok; k++) begin
      rdy = snk_ready_o;
      step();
      ok = rdy;
    end
    snk_valid_i = 1'b0;
    if (!ok) chk("send_timeout", 64'(ok), 64'(1));
  endtask

  task automatic send_pkt(input int id, input int n, input logic err);
    for (int i = 0; i < n; i++) send_word(id, i, i == 0, i == n-1, err && (i == n-1));
  endtask

  task automatic do_reset();
    rst_i = 1'b1; step(); step(); rst_i = 1'b0; step();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    int rd0, sop0, dr0, pk_max;
    @(negedge clk_i);
    do_reset();
    chk("rst_used", 64'(used_words_o), 64'(0));
    chk("rst_pkts", 64'(pkts_amount_o), 64'(0));
    chk("rst_empty", 64'(empty_o), 64'(1));
    chk("rst_valid", 64'(src_valid_o), 64'(0));
    chk("rst_ready", 64'(snk_ready_o), 64'(1));
    chk("rst_full", 64'(full_o), 64'(0));
    chk("rst_data", src_data_o, 64'(0));
    chk("rst_dcnt", 64'(drop_cnt_o), 64'(0));

    // 3-word packet: valid two cycles after the eop edge, then back-to-back.
    send_pkt(1, 3, 1'b0);
    chk("t1_used_n", 64'(used_words_o), 64'(3));
    chk("t1_pkts_n", 64'(pkts_amount_o), 64'(1));
    chk("t1_vld_n", 64'(src_valid_o), 64'(0));
    step(); chk("t1_vld_n1", 64'(src_valid_o), 64'(0));
    step(); chk("t1_vld_n2", 64'(src_valid_o), 64'(1));
    chk("t1_w0", src_data_o, 64'hA000_0000_0000_0100);
    chk("t1_sop0", 64'(src_sop_o), 64'(1));
    step(); chk("t1_w1", src_data_o, 64'hA000_0000_0000_0101);
    chk("t1_vld1", 64'(src_valid_o), 64'(1));
    step(); chk("t1_w2", src_data_o, 64'hA000_0000_0000_0102);
    chk("t1_eop2", 64'(src_eop_o), 64'(1));
    step(); chk("t1_vld_end", 64'(src_valid_o), 64'(0));
    chk("t1_used_end", 64'(used_words_o), 64'(0));
    chk("t1_pkts_end", 64'(pkts_amount_o), 64'(0));

    // Oversized packet is dropped once.
    do_reset();
    dr0 = n_drop; vld_seen = 1'b0;
    send_pkt(2, 20, 1'b0);
    idle(4);
    chk("t2_drops", 64'(n_drop - dr0), 64'(1));
    chk("t2_used", 64'(used_words_o), 64'(0));
    chk("t2_vld_seen", 64'(vld_seen), 64'(0));
    chk("t2_dcnt", 64'(drop_cnt_o), CNT_ON ? 64'(1) : 64'(0));

    // Errored packet dropped, following clean packet delivered.
    do_reset();
    dr0 = n_drop; rd0 = n_rd; sop0 = n_sop;
    send_pkt(3, 4, 1'b1);
    send_pkt(4, 2, 1'b0);
    idle(8);
    chk("t3_rd", 64'(n_rd - rd0), 64'(2));
    chk("t3_sop", 64'(n_sop - sop0), 64'(1));
    chk("t3_drops", 64'(n_drop - dr0), 64'(1));
    chk("t3_dcnt", 64'(drop_cnt_o), CNT_ON ? 64'(1) : 64'(0));

    // New sop mid-packet restarts with the new packet.
    do_reset();
    dr0 = n_drop; rd0 = n_rd; pk_max = 0;
    send_word(5, 0, 1'b1, 1'b0, 1'b0);
    send_word(5, 1, 1'b0, 1'b0, 1'b0);
    send_word(5, 2, 1'b0, 1'b0, 1'b0);
    send_word(6, 0, 1'b1, 1'b0, 1'b0);
    send_word(6, 1, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      if (int'(pkts_amount_o) > pk_max) pk_max = int'(pkts_amount_o);
      step();
    end
    chk("t4_rd", 64'(n_rd - rd0), 64'(2));
    chk("t4_drops", 64'(n_drop - dr0), 64'(1));
    chk("t4_pk_max", 64'(pk_max), 64'(1));
    chk("t4_used", 64'(used_words_o), 64'(0));

    // Cut-through mode fills to 16 then backpressures.
    drop_mode_i = 1'b0;
    do_reset();
    idle(2);
    src_ready_i = 1'b0;
    dr0 = n_drop; rd0 = n_rd;
    for (int i = 0; i < 16; i++) send_word(7, i, i == 0, 1'b0, 1'b0);
    chk("t5_used16", 64'(used_words_o), 64'(16));
    chk("t5_full", 64'(full_o), 64'(1));
    chk("t5_ready_lo", 64'(snk_ready_o), 64'(0));
    chk("t5_afull", 64'(almost_full_o), 64'(1));
    snk_data_i = wd(7, 16); snk_sop_i = 1'b0; snk_eop_i = 1'b0; snk_error_i = 1'b0;
    snk_valid_i = 1'b1;
    idle(3);
    chk("t5_hold_used", 64'(used_words_o), 64'(16));
    chk("t5_hold_rdy", 64'(snk_ready_o), 64'(0));
    src_ready_i = 1'b1;
    send_word(7, 16, 1'b0, 1'b0, 1'b0);
    send_word(7, 17, 1'b0, 1'b1, 1'b1);
    idle(25);
    chk("t5_rd", 64'(n_rd - rd0), 64'(18));
    chk("t5_last_err", 64'(last_err), 64'(1));
    chk("t5_used_end", 64'(used_words_o), 64'(0));
    chk("t5_drops", 64'(n_drop - dr0), 64'(0));

    // Asynchronous reset in the middle of a packet.
    drop_mode_i = 1'b1;
    do_reset();
    src_ready_i = 1'b0;
    send_pkt(8, 5, 1'b0);
    send_word(9, 0, 1'b1, 1'b0, 1'b0);
    send_word(9, 1, 1'b0, 1'b0, 1'b0);
    chk("t6_used_pre", 64'(used_words_o), 64'(7));
    chk("t6_pkts_pre", 64'(pkts_amount_o), 64'(1));
    rst_i = 1'b1;
    step();
    chk("t6_used", 64'(used_words_o), 64'(0));
    chk("t6_pkts", 64'(pkts_amount_o), 64'(0));
    chk("t6_empty", 64'(empty_o), 64'(1));
    chk("t6_valid", 64'(src_valid_o), 64'(0));
    chk("t6_ready", 64'(snk_ready_o), 64'(1));
    chk("t6_data", src_data_o, 64'(0));
    rst_i = 1'b0;
    src_ready_i = 1'b1;
    step();
    rd0 = n_rd;
    send_pkt(10, 2, 1'b0);
    idle(8);
    chk("t6_rd", 64'(n_rd - rd0), 64'(2));
    chk("t6_used_end", 64'(used_words_o), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
